// File: rtl/lcd_reader.sv
// lcd_reader -- read-side engine for an HD44780-style 8-bit character LCD bus.
//
// Runs single RW=1 bus cycles: RS=0 returns the status byte {BF, AC[6:0]},
// RS=1 returns the DDRAM/CGRAM byte at the cursor. The pins are meant to be
// muxed with a write engine at the top level; idle levels (rs=0, rw=0, en=0)
// match the write engine's idle levels so the mux switch is glitch-free.
//
// Optional feature macro: LCD_RD_BUSY_POLL_EN
//   When defined, an rd_rs=1 request first polls the busy flag with status
//   cycles (up to POLL_MAX of them) and only then runs the data cycle. If the
//   flag never clears, the last status byte is returned with rd_timeout=1.
//
// Parameters:
//   SETUP_CYC  clk cycles RS/RW stable before EN rises (1..255)
//   EN_CYC     clk cycles EN held high (1..255)
//   HOLD_CYC   clk cycles RS/RW held after EN falls (1..255)
//   POLL_MAX   max busy-flag reads before giving up (1..255, poll build only)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   rd_req     in   read request, sampled while busy=0
//   rd_rs      in   register select for the request (0=status, 1=data)
//   lcd_db_in  in   LCD data bus pad input
//   lcd_rs     out  LCD RS pin
//   lcd_rw     out  LCD RW pin (1 = LCD drives the bus)
//   lcd_en     out  LCD E pin
//   rd_data    out  captured byte, held until the next capture
//   rd_valid   out  one-cycle completion pulse
//   rd_timeout out  qualifies rd_valid: busy poll gave up
//   busy       out  transaction in progress
module lcd_reader #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int POLL_MAX  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_rs,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       rd_timeout,
    output logic       busy
);

    // Elaboration-time range checks on the timing parameters.
    if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_chk_setup
        $error("SETUP_CYC out of range");
    end
    if (EN_CYC < 1 || EN_CYC > 255) begin : g_chk_en
        $error("EN_CYC out of range");
    end
    if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_chk_hold
        $error("HOLD_CYC out of range");
    end
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_chk_poll
        $error("POLL_MAX out of range");
    end

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] EN_LAST    = 8'(EN_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EN_HI = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;          // phase counter shared by all states
    logic       cyc_rs_q, cyc_rs_d;    // RS level of the bus cycle in flight
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       tmo_q, tmo_d;
    logic       en_q, en_d;
    logic       rw_q, rw_d;
    logic       rs_q, rs_d;
    logic       busy_q, busy_d;

`ifdef LCD_RD_BUSY_POLL_EN
    localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);
    logic       want_data_q, want_data_d;   // request was rd_rs=1: data cycle pending
    logic [7:0] poll_q, poll_d;             // status reads completed minus one
`endif

    // State register (all state and registered pin outputs)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 8'h00;
            cyc_rs_q <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            en_q     <= 1'b0;
            rw_q     <= 1'b0;
            rs_q     <= 1'b0;
            busy_q   <= 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
            want_data_q <= 1'b0;
            poll_q      <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cyc_rs_q <= cyc_rs_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            tmo_q    <= tmo_d;
            en_q     <= en_d;
            rw_q     <= rw_d;
            rs_q     <= rs_d;
            busy_q   <= busy_d;
`ifdef LCD_RD_BUSY_POLL_EN
            want_data_q <= want_data_d;
            poll_q      <= poll_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cyc_rs_d = cyc_rs_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        tmo_d    = 1'b0;
`ifdef LCD_RD_BUSY_POLL_EN
        want_data_d = want_data_q;
        poll_d      = poll_q;
`endif
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = SETUP;
                    cnt_d   = 8'h00;
`ifdef LCD_RD_BUSY_POLL_EN
                    // Data requests start with a status read; status requests are a single cycle.
                    cyc_rs_d    = 1'b0;
                    want_data_d = rd_rs;
                    poll_d      = 8'h00;
`else
                    cyc_rs_d = rd_rs;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = EN_HI;
                    cnt_d   = 8'h00;
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            EN_HI: begin
                if (cnt_q == EN_LAST) begin
                    state_d = HOLD;
                    cnt_d   = 8'h00;
                    data_d  = lcd_db_in;   // capture on the edge that lowers EN
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = 8'h00;
                    state_d = IDLE;
                    valid_d = 1'b1;
`ifdef LCD_RD_BUSY_POLL_EN
                    // After a poll read, chain straight into the next bus cycle (no idle gap).
                    if (want_data_q && !cyc_rs_q) begin
                        if (!data_q[7]) begin
                            state_d  = SETUP;
                            valid_d  = 1'b0;
                            cyc_rs_d = 1'b1;
                        end else if (poll_q == POLL_LAST) begin
                            tmo_d = 1'b1;
                        end else begin
                            state_d = SETUP;
                            valid_d = 1'b0;
                            poll_d  = poll_q + 8'h01;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'h00;
            end
        endcase
    end

    // Output logic: pins are registered decodes of the next state, so they
    // change only on clock edges and RS/RW can only move while EN is low.
    always_comb begin
        en_d   = (state_d == EN_HI);
        rw_d   = (state_d != IDLE);
        rs_d   = (state_d != IDLE) && cyc_rs_d;
        busy_d = (state_d != IDLE);
    end

    assign lcd_rs     = rs_q;
    assign lcd_rw     = rw_q;
    assign lcd_en     = en_q;
    assign rd_data    = data_q;
    assign rd_valid   = valid_q;
    assign rd_timeout = tmo_q;
    assign busy       = busy_q;

endmodule
